// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    HALT
  } fetch_state_t;

  localparam int FETCH_LAT_MAX = 4;
  localparam int FETCH_CNT_W   = $clog2(FETCH_LAT_MAX);

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, instruction memory, decode and execute.
interface instr_fetch_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_lat_timer.sv
// Load/count/done counter that marks the cycle in which memory read data is valid.
module fetch_lat_timer
  import fetch_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  logic [FETCH_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == FETCH_CNT_W'(LAT - 1));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: PC ownership, one-at-a-time memory reads, decode handshake.
// Optional build macro FETCH_TRACE_EN prints every accepted instruction.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned NUM_INSTR   = 3,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] RESET_PC    = 32'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_fetch_ctrl_if.master  bus,
  output logic                busy,
  output logic                halted
);

  localparam logic [31:0] END_PC = 32'(NUM_INSTR);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic [31:0]  pc_inc;
  logic         tmr_load, tmr_en, tmr_done;
  logic         redir_act;

  assign pc_inc    = pc_q + 32'd1;
  assign redir_act = bus.redirect_valid &&
                     (state_q == FETCH || state_q == WAIT || state_q == HOLD);

  fetch_lat_timer #(.LAT(MEM_LATENCY)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = (pc_q >= END_PC) ? HALT : FETCH;
      FETCH: begin
        addr_d   = pc_q;
        tmr_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          instr_d = bus.imem_rdata;
          ipc_d   = pc_q;
          state_d = HOLD;
        end
      end
      HOLD: if (bus.instr_ready) begin
        pc_d    = pc_inc;
        state_d = (pc_inc < END_PC) ? FETCH : HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    // Redirect wins over sequencing; an in-flight read is dropped uncaptured.
    if (redir_act) begin
      pc_d    = bus.redirect_pc;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      state_d = (bus.redirect_pc >= END_PC) ? HALT : FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = (state_q == FETCH) ? pc_q : addr_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign busy            = (state_q == FETCH) || (state_q == WAIT) || (state_q == HOLD);
  assign halted          = (state_q == HALT);

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && state_q == HOLD && bus.instr_ready)
      $display("Instruction : %b , PC : %b", instr_q, ipc_q);
  end
`else
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench: table of per-cycle vectors on a latency-1 instance, hand sequence on latency 3.
module tb_instr_fetch_ctrl;
  import fetch_pkg::*;

  localparam int L1 = 1;
  localparam int L2 = 3;
  localparam logic [31:0] WA  = 32'h1111_0000;
  localparam logic [31:0] WB  = 32'h2222_0001;
  localparam logic [31:0] WC  = 32'h3333_0002;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst1, rst2, start1, start2;
  logic busy1, busy2, halted1, halted2;

  instr_fetch_ctrl_if if1 ();
  instr_fetch_ctrl_if if2 ();

  instr_fetch_ctrl #(.NUM_INSTR(3), .MEM_LATENCY(L1), .RESET_PC(32'd0)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .bus(if1), .busy(busy1), .halted(halted1)
  );

  instr_fetch_ctrl #(.NUM_INSTR(3), .MEM_LATENCY(L2), .RESET_PC(32'd0)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .bus(if2), .busy(busy2), .halted(halted2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input logic [31:0] a);
    case (a)
      32'd0:   return WA;
      32'd1:   return WB;
      32'd2:   return WC;
      default: return BAD;
    endcase
  endfunction

  // Fixed-latency memory models; data is valid only in the exact latency cycle.
  logic [3:0]  v1 = '0;
  logic [3:0]  v2 = '0;
  logic [31:0] a1 [4];
  logic [31:0] a2 [4];

  always @(posedge clk) begin
    v1 <= {v1[2:0], if1.imem_req};
    v2 <= {v2[2:0], if2.imem_req};
    a1[0] <= if1.imem_addr;
    a2[0] <= if2.imem_addr;
    for (int k = 1; k < 4; k++) begin
      a1[k] <= a1[k-1];
      a2[k] <= a2[k-1];
    end
  end

  assign if1.imem_rdata = v1[L1-1] ? mword(a1[L1-1]) : BAD;
  assign if2.imem_rdata = v2[L2-1] ? mword(a2[L2-1]) : BAD;

  typedef struct {
    logic        r, s, rd, rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ins, e_ipc;
    logic        e_busy, e_halt;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic r, s, rd, rv, input logic [31:0] rpc,
                     input logic req, input logic [31:0] addr, input logic vld,
                     input logic [31:0] ins, ipc, input logic bsy, hlt);
    vec_t v;
    v.r = r; v.s = s; v.rd = rd; v.rv = rv; v.rpc = rpc;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld;
    v.e_ins = ins; v.e_ipc = ipc; v.e_busy = bsy; v.e_halt = hlt;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int k;
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    if1.instr_ready = 1'b0; if1.redirect_valid = 1'b0; if1.redirect_pc = '0;
    if2.instr_ready = 1'b0; if2.redirect_valid = 1'b0; if2.redirect_pc = '0;

    //   r s rd rv rpc    req addr vld ins ipc busy halt
    add(0,1,1,0,0,  0,0,0,0, 0,0,0);   // idle, start
    add(0,0,1,0,0,  1,0,0,0, 0,1,0);   // fetch pc0
    add(0,0,1,0,0,  0,0,0,0, 0,1,0);
    add(0,0,1,0,0,  0,0,1,WA,0,1,0);   // A valid
    add(0,0,1,0,0,  1,1,0,WA,0,1,0);
    add(0,0,1,0,0,  0,1,0,WA,0,1,0);
    add(0,0,1,0,0,  0,1,1,WB,1,1,0);   // B valid
    add(0,0,1,0,0,  1,2,0,WB,1,1,0);
    add(0,0,1,0,0,  0,2,0,WB,1,1,0);
    add(0,0,1,0,0,  0,2,1,WC,2,1,0);   // C valid, accepted
    add(0,0,1,0,0,  0,2,0,WC,2,0,1);   // halted
    add(0,1,1,0,0,  0,2,0,WC,2,0,1);   // start ignored
    add(0,0,1,1,0,  0,2,0,WC,2,0,1);   // redirect ignored
    add(1,0,1,0,0,  0,0,0,0, 0,0,0);   // async reset from halt
    add(0,1,1,0,0,  0,0,0,0, 0,0,0);
    add(0,0,1,0,0,  1,0,0,0, 0,1,0);
    add(0,0,1,0,0,  0,0,0,0, 0,1,0);
    add(0,0,1,0,0,  0,0,1,WA,0,1,0);
    add(0,0,1,0,0,  1,1,0,WA,0,1,0);
    add(0,0,1,0,0,  0,1,0,WA,0,1,0);
    add(0,0,1,0,0,  0,1,1,WB,1,1,0);
    add(0,0,1,0,0,  1,2,0,WB,1,1,0);
    add(0,0,1,1,0,  0,2,0,WB,1,1,0);   // redirect to 0 in WAIT of pc2
    add(0,0,1,0,0,  1,0,0,WB,1,1,0);   // C not captured
    add(0,0,1,0,0,  0,0,0,WB,1,1,0);
    add(0,0,1,1,2,  0,0,1,WA,0,1,0);   // accept + redirect to 2
    add(0,0,1,0,0,  1,2,0,WA,0,1,0);
    add(0,0,1,0,0,  0,2,0,WA,0,1,0);
    add(0,0,0,1,7,  0,2,1,WC,2,1,0);   // redirect out of range
    add(0,0,1,0,0,  0,2,0,WC,2,0,1);
    add(0,0,1,0,0,  0,2,0,WC,2,0,1);
    add(1,0,1,0,0,  0,0,0,0, 0,0,0);
    add(0,1,1,0,0,  0,0,0,0, 0,0,0);
    add(0,0,1,0,0,  1,0,0,0, 0,1,0);
    add(1,0,1,0,0,  0,0,0,0, 0,0,0);   // reset in WAIT
    add(0,0,1,0,0,  0,0,0,0, 0,0,0);
    add(0,1,1,0,0,  0,0,0,0, 0,0,0);
    add(0,0,1,0,0,  1,0,0,0, 0,1,0);
    add(0,0,1,0,0,  0,0,0,0, 0,1,0);
    add(0,0,1,0,0,  0,0,1,WA,0,1,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      rst1 = vq[i].r; start1 = vq[i].s; if1.instr_ready = vq[i].rd;
      if1.redirect_valid = vq[i].rv; if1.redirect_pc = vq[i].rpc;
      #1;
      chk($sformatf("v%0d req", i),   32'(if1.imem_req),    32'(vq[i].e_req));
      chk($sformatf("v%0d addr", i),  if1.imem_addr,        vq[i].e_addr);
      chk($sformatf("v%0d valid", i), 32'(if1.instr_valid), 32'(vq[i].e_vld));
      chk($sformatf("v%0d instr", i), if1.instr,            vq[i].e_ins);
      chk($sformatf("v%0d ipc", i),   if1.instr_pc,         vq[i].e_ipc);
      chk($sformatf("v%0d busy", i),  32'(busy1),           32'(vq[i].e_busy));
      chk($sformatf("v%0d halted", i), 32'(halted1),        32'(vq[i].e_halt));
    end

    // Latency 3 with decode stalling for 5 cycles on the first word.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    #1;
    chk("l3 req0", 32'(if2.imem_req), 32'd1);
    chk("l3 addr0", if2.imem_addr, 32'd0);
    k = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk); #1;
      if (if2.instr_valid) begin k = n; break; end
    end
    chk("l3 lat0", 32'(k), 32'd4);
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("l3 stall%0d valid", n), 32'(if2.instr_valid), 32'd1);
      chk($sformatf("l3 stall%0d instr", n), if2.instr, WA);
      chk($sformatf("l3 stall%0d ipc", n), if2.instr_pc, 32'd0);
      chk($sformatf("l3 stall%0d req", n), 32'(if2.imem_req), 32'd0);
      @(negedge clk); #1;
    end
    if2.instr_ready = 1'b1;
    chk("l3 acc valid", 32'(if2.instr_valid), 32'd1);
    @(negedge clk);
    if2.instr_ready = 1'b0;
    #1;
    chk("l3 req1", 32'(if2.imem_req), 32'd1);
    chk("l3 addr1", if2.imem_addr, 32'd1);
    chk("l3 valid drop", 32'(if2.instr_valid), 32'd0);
    k = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk); #1;
      if (if2.instr_valid) begin k = n; break; end
    end
    chk("l3 lat1", 32'(k), 32'd4);
    chk("l3 instr1", if2.instr, WB);
    chk("l3 ipc1", if2.instr_pc, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
